// File: rtl/act_fn_pkg.sv
// Shared constants and helpers for the 4-bit tanh activation family.
// Used by the forward circuits and the gradient stream.
package act_fn_pkg;

  localparam int YW_DEF = 4;
  localparam int GW_DEF = 8;
  localparam int ONE_Q  = 1 << (2 * YW_DEF);

  // Arithmetic right shift by sh with round-half-toward-+inf.
  function automatic logic signed [31:0] round_shift(
    input logic signed [31:0] p,
    input int                 sh
  );
    logic signed [31:0] bias;
    bias = 32'sd1 <<< (sh - 1);
    return (p + bias) >>> sh;
  endfunction

endpackage

// File: rtl/tanh_grad_core.sv
// Combinational datapath for the tanh backward pass:
// om = 1 - y^2, then r = round(g * om).
module tanh_grad_core
  import act_fn_pkg::*;
#(
  parameter int YW = YW_DEF,
  parameter int GW = GW_DEF
) (
  input  logic        [YW-1:0]   y,
  output logic        [2*YW:0]   om,
  input  logic signed [GW-1:0]   g,
  input  logic        [2*YW:0]   om_q,
  output logic signed [GW-1:0]   r
);

  localparam int PW = GW + 2 * YW + 1;
  localparam logic [2*YW:0] ONE =
    (2 * YW + 1)'(1) << (2 * YW);

  logic        [2*YW-1:0] sq;
  logic signed [PW-1:0]   g_x;
  logic signed [PW-1:0]   om_x;
  logic signed [PW-1:0]   p;

  // Square and complement feeding stage 1.
  always_comb begin
    sq = {YW'(0), y} * {YW'(0), y};
    om = ONE - {1'b0, sq};
  end

  // Scale the gradient; |om| <= 1.0 so r always fits GW bits.
  always_comb begin
    g_x  = PW'(g);
    om_x = PW'(om_q);
    p    = g_x * om_x;
    r    = GW'(round_shift(32'(p), 2 * YW));
  end

endmodule

// File: rtl/tanh_grad_4bit_stream.sv
// Two-stage streaming tanh gradient: g_in = g * (1 - y^2).
// Valid/ready on both sides, full throughput, no bubbles.
module tanh_grad_4bit_stream
  import act_fn_pkg::*;
#(
  parameter int YW = YW_DEF,
  parameter int GW = GW_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic        [YW-1:0] in_y,
  input  logic signed [GW-1:0] in_g,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [GW-1:0] out_g,
  output logic                 busy
);

  logic                 s1_valid;
  logic        [2*YW:0] s1_om;
  logic signed [GW-1:0] s1_g;
  logic                 s2_valid;

  logic                 s1_adv;
  logic                 s2_adv;
  logic                 in_fire;
  logic        [2*YW:0] om_c;
  logic signed [GW-1:0] r_c;

  tanh_grad_core #(
    .YW (YW),
    .GW (GW)
  ) u_core (
    .y    (in_y),
    .om   (om_c),
    .g    (s1_g),
    .om_q (s1_om),
    .r    (r_c)
  );

  // Handshake: in_ready depends only on pipeline state and out_ready.
  always_comb begin
    s2_adv    = !s2_valid || out_ready;
    s1_adv    = s1_valid && s2_adv;
    in_ready  = !s1_valid || s2_adv;
    in_fire   = in_valid && in_ready;
    out_valid = s2_valid;
    busy      = s1_valid || s2_valid;
  end

  // Stage 1 register: refilled on accept, emptied on advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_om    <= '0;
      s1_g     <= '0;
    end else if (in_fire) begin
      s1_valid <= 1'b1;
      s1_om    <= om_c;
      s1_g     <= in_g;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage 2 register: holds the result until downstream takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      out_g    <= '0;
    end else if (s1_adv) begin
      s2_valid <= 1'b1;
      out_g    <= r_c;
    end else if (s2_valid && out_ready) begin
      s2_valid <= 1'b0;
    end
  end

endmodule
